// File: rtl/fir_gen_pipe.sv
// Transposed-form FIR with a serially loaded coefficient bank, pipelined multipliers
// and a rounded, saturated output register. Sample gaps freeze the adder chain.
module fir_gen_pipe #(
   parameter int W1    = 9,
   parameter int W2    = 18,
   parameter int W3    = 20,
   parameter int W4    = 11,
   parameter int L     = 4,
   parameter int MPIPE = 3,
   parameter int SHIFT = 8,
   parameter int ROUND = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clr,
   input  logic          c_load,
   input  logic [W1-1:0] c_in,
   input  logic          x_valid,
   input  logic [W1-1:0] x_in,
   output logic          y_valid,
   output logic [W4-1:0] y_out,
   output logic          ovf
);

   localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic signed [W3:0] RND_C =
      (ROUND != 0 && SHIFT > 0) ? ((W3+1)'(1) << RSH) : '0;
   localparam logic signed [W3:0] YMAX = (W3+1)'((64'sd1 <<< (W4-1)) - 64'sd1);
   localparam logic signed [W3:0] YMIN = (W3+1)'(-(64'sd1 <<< (W4-1)));

   logic signed [W1-1:0] coef [L];
   logic signed [W1-1:0] xr;
   logic                 xv;
   logic signed [W2-1:0] prod [MPIPE][L];
   logic [MPIPE-1:0]     pv;
   logic signed [W3-1:0] acc [L];
   logic                 av;
   logic signed [W3:0]   rnd;
   logic signed [W3:0]   shf;

   // Coefficient bank shifts toward c[0]; clr never touches it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < L; k++) coef[k] <= '0;
      end else if (c_load) begin
         for (int k = 0; k < L-1; k++) coef[k] <= coef[k+1];
         coef[L-1] <= c_in;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         xr <= '0;
         xv <= 1'b0;
      end else if (clr) begin
         xr <= '0;
         xv <= 1'b0;
      end else begin
         xv <= x_valid;
         if (x_valid) xr <= x_in;
      end
   end

   // Stage 0 multiplies with the bank as it stands after any load on the capture edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pv <= '0;
         for (int s = 0; s < MPIPE; s++)
            for (int k = 0; k < L; k++) prod[s][k] <= '0;
      end else if (clr) begin
         pv <= '0;
         for (int s = 0; s < MPIPE; s++)
            for (int k = 0; k < L; k++) prod[s][k] <= '0;
      end else begin
         pv[0] <= xv;
         if (xv)
            for (int k = 0; k < L; k++) prod[0][k] <= W2'(xr) * W2'(coef[k]);
         for (int s = 1; s < MPIPE; s++) begin
            pv[s] <= pv[s-1];
            for (int k = 0; k < L; k++) prod[s][k] <= prod[s-1][k];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         av <= 1'b0;
         for (int k = 0; k < L; k++) acc[k] <= '0;
      end else if (clr) begin
         av <= 1'b0;
         for (int k = 0; k < L; k++) acc[k] <= '0;
      end else begin
         av <= pv[MPIPE-1];
         if (pv[MPIPE-1]) begin
            acc[L-1] <= W3'(prod[MPIPE-1][L-1]);
            for (int k = 0; k < L-1; k++)
               acc[k] <= W3'(prod[MPIPE-1][k]) + acc[k+1];
         end
      end
   end

   // One guard bit above the accumulator keeps the rounding add from wrapping.
   always_comb begin
      rnd = (W3+1)'(acc[0]) + RND_C;
      shf = rnd >>> SHIFT;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         y_valid <= 1'b0;
         y_out   <= '0;
         ovf     <= 1'b0;
      end else if (clr) begin
         y_valid <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         y_valid <= av;
         if (av) begin
            if (shf > YMAX) begin
               y_out <= YMAX[W4-1:0];
               ovf   <= 1'b1;
            end else if (shf < YMIN) begin
               y_out <= YMIN[W4-1:0];
               ovf   <= 1'b1;
            end else begin
               y_out <= shf[W4-1:0];
               ovf   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fir_gen_pipe.sv
// Directed bench for fir_gen_pipe: three instances (unscaled, rounded, truncated)
// share one stimulus stream; each task checks the instance relevant to it.
`timescale 1ns/1ps
module tb_fir_gen_pipe;

   typedef struct {
      int   v;
      logic o;
      int   c;
   } rec_t;

   logic        clk;
   logic        reset_n;
   logic        clr;
   logic        c_load;
   logic [8:0]  c_in;
   logic        x_valid;
   logic [8:0]  x_in;

   logic        yv_imp, ov_imp;
   logic [19:0] y_imp;
   logic        yv_def, ov_def;
   logic [10:0] y_def;
   logic        yv_trn, ov_trn;
   logic [10:0] y_trn;

   rec_t q_imp[$];
   rec_t q_def[$];
   rec_t q_trn[$];
   int   cyc   = 0;
   int   tests = 0;
   int   fails = 0;

   fir_gen_pipe #(.SHIFT(0), .ROUND(0), .W4(20)) u_imp (
      .clk(clk), .reset_n(reset_n), .clr(clr), .c_load(c_load), .c_in(c_in),
      .x_valid(x_valid), .x_in(x_in), .y_valid(yv_imp), .y_out(y_imp), .ovf(ov_imp));

   fir_gen_pipe u_def (
      .clk(clk), .reset_n(reset_n), .clr(clr), .c_load(c_load), .c_in(c_in),
      .x_valid(x_valid), .x_in(x_in), .y_valid(yv_def), .y_out(y_def), .ovf(ov_def));

   fir_gen_pipe #(.ROUND(0)) u_trn (
      .clk(clk), .reset_n(reset_n), .clr(clr), .c_load(c_load), .c_in(c_in),
      .x_valid(x_valid), .x_in(x_in), .y_valid(yv_trn), .y_out(y_trn), .ovf(ov_trn));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every wait goes through here so output capture stays in one process.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (yv_imp) q_imp.push_back(rec_t'{int'($signed(y_imp)), ov_imp, cyc});
      if (yv_def) q_def.push_back(rec_t'{int'($signed(y_def)), ov_def, cyc});
      if (yv_trn) q_trn.push_back(rec_t'{int'($signed(y_trn)), ov_trn, cyc});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input int v);
      x_valid = 1'b1;
      x_in    = 9'(v);
      tick();
      x_valid = 1'b0;
   endtask

   task automatic load4(input int a, input int b, input int c, input int d);
      int v[4];
      v = '{a, b, c, d};
      for (int i = 0; i < 4; i++) begin
         c_load = 1'b1;
         c_in   = 9'(v[i]);
         tick();
      end
      c_load = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic flush_q();
      q_imp.delete();
      q_def.delete();
      q_trn.delete();
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle(2);
      tests++;
      if ({yv_imp, yv_def, yv_trn} !== 3'b000) begin
         fails++; $display("FAIL reset_y_valid: got %b, want 000", {yv_imp, yv_def, yv_trn});
      end
      tests++;
      if (y_imp !== 20'd0 || y_def !== 11'd0) begin
         fails++; $display("FAIL reset_y_out: got %0d/%0d, want 0/0", y_imp, y_def);
      end
      tests++;
      if ({ov_imp, ov_def, ov_trn} !== 3'b000) begin
         fails++; $display("FAIL reset_ovf: got %b, want 000", {ov_imp, ov_def, ov_trn});
      end
      reset_n = 1'b1;
      idle(1);
   endtask

   task automatic test_impulse();
      int e[5] = '{1, 2, 3, 4, 0};
      int s;
      load4(1, 2, 3, 4);
      do_clr();
      flush_q();
      s = cyc + 1;
      for (int i = 0; i < 5; i++) send(i == 0 ? 1 : 0);
      idle(12);
      tests++;
      if (q_imp.size() !== 5) begin
         fails++; $display("FAIL impulse_count: got %0d, want 5", q_imp.size());
      end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (i >= q_imp.size() || q_imp[i].v !== e[i]) begin
            fails++; $display("FAIL impulse_y[%0d]: got %0d, want %0d", i,
                              (i < q_imp.size()) ? q_imp[i].v : -999, e[i]);
         end
      end
      tests++;
      if (q_imp.size() == 0 || q_imp[0].c !== s + 5) begin
         fails++; $display("FAIL impulse_latency: got cycle %0d, want %0d",
                           (q_imp.size() > 0) ? q_imp[0].c : -1, s + 5);
      end
      tests++;
      if (q_imp.size() < 5 || q_imp[4].c - q_imp[0].c !== 4) begin
         fails++; $display("FAIL impulse_back_to_back: outputs not on consecutive cycles");
      end
   endtask

   task automatic test_gapped();
      int e[5] = '{1, 2, 3, 4, 0};
      do_clr();
      flush_q();
      for (int i = 0; i < 5; i++) begin
         send(i == 0 ? 1 : 0);
         idle(2);
      end
      idle(10);
      tests++;
      if (q_imp.size() !== 5) begin
         fails++; $display("FAIL gapped_count: got %0d, want 5", q_imp.size());
      end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (i >= q_imp.size() || q_imp[i].v !== e[i]) begin
            fails++; $display("FAIL gapped_y[%0d]: got %0d, want %0d", i,
                              (i < q_imp.size()) ? q_imp[i].v : -999, e[i]);
         end
      end
      for (int i = 1; i < 5; i++) begin
         tests++;
         if (i >= q_imp.size() || q_imp[i].c - q_imp[i-1].c !== 3) begin
            fails++; $display("FAIL gapped_spacing[%0d]: got %0d, want 3", i,
                              (i < q_imp.size()) ? q_imp[i].c - q_imp[i-1].c : -1);
         end
      end
   endtask

   task automatic test_flush();
      int e[4] = '{1, 2, 3, 4};
      do_clr();
      flush_q();
      send(1);
      send(0);
      do_clr();
      idle(12);
      tests++;
      if (q_imp.size() !== 0) begin
         fails++; $display("FAIL flush_no_output: got %0d outputs, want 0", q_imp.size());
      end
      for (int i = 0; i < 4; i++) send(i == 0 ? 1 : 0);
      idle(12);
      tests++;
      if (q_imp.size() !== 4) begin
         fails++; $display("FAIL flush_reimpulse_count: got %0d, want 4", q_imp.size());
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (i >= q_imp.size() || q_imp[i].v !== e[i]) begin
            fails++; $display("FAIL flush_reimpulse_y[%0d]: got %0d, want %0d", i,
                              (i < q_imp.size()) ? q_imp[i].v : -999, e[i]);
         end
      end
   endtask

   task automatic test_concurrency();
      int e[5] = '{2, 3, 4, 5, 0};
      do_clr();
      flush_q();
      clr = 1'b1; x_valid = 1'b1; x_in = 9'd1;
      tick();
      clr = 1'b0; x_valid = 1'b0;
      idle(12);
      tests++;
      if (q_imp.size() !== 0) begin
         fails++; $display("FAIL clr_with_x: got %0d outputs, want 0", q_imp.size());
      end
      c_load = 1'b1; c_in = 9'd5; x_valid = 1'b1; x_in = 9'd1;
      tick();
      c_load = 1'b0; x_valid = 1'b0;
      for (int i = 0; i < 4; i++) send(0);
      idle(12);
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (i >= q_imp.size() || q_imp[i].v !== e[i]) begin
            fails++; $display("FAIL cload_with_x_y[%0d]: got %0d, want %0d", i,
                              (i < q_imp.size()) ? q_imp[i].v : -999, e[i]);
         end
      end
   endtask

   task automatic test_rounding();
      int ed[2] = '{1, 0};
      int et[2] = '{0, -1};
      int ei[2] = '{128, -128};
      load4(1, 0, 0, 0);
      do_clr();
      flush_q();
      send(128);
      send(-128);
      idle(12);
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (i >= q_def.size() || q_def[i].v !== ed[i]) begin
            fails++; $display("FAIL round_on_y[%0d]: got %0d, want %0d", i,
                              (i < q_def.size()) ? q_def[i].v : -999, ed[i]);
         end
         tests++;
         if (i >= q_trn.size() || q_trn[i].v !== et[i]) begin
            fails++; $display("FAIL round_off_y[%0d]: got %0d, want %0d", i,
                              (i < q_trn.size()) ? q_trn[i].v : -999, et[i]);
         end
         tests++;
         if (i >= q_imp.size() || q_imp[i].v !== ei[i]) begin
            fails++; $display("FAIL round_noshift_y[%0d]: got %0d, want %0d", i,
                              (i < q_imp.size()) ? q_imp[i].v : -999, ei[i]);
         end
      end
   endtask

   task automatic test_saturation();
      int       ev[6] = '{256, 512, 768, 1023, 1023, 1023};
      bit [5:0] eo    = 6'b111000;
      load4(-256, -256, -256, -256);
      do_clr();
      flush_q();
      for (int i = 0; i < 6; i++) send(-256);
      idle(12);
      for (int i = 0; i < 6; i++) begin
         tests++;
         if (i >= q_def.size() || q_def[i].v !== ev[i] || q_def[i].o !== eo[i]) begin
            fails++; $display("FAIL sat_y[%0d]: got %0d ovf %0b, want %0d ovf %0b", i,
                              (i < q_def.size()) ? q_def[i].v : -999,
                              (i < q_def.size()) ? q_def[i].o : 1'bx, ev[i], eo[i]);
         end
      end
      tests++;
      if (q_imp.size() < 4 || q_imp[3].v !== 262144 || q_imp[3].o !== 1'b0) begin
         fails++; $display("FAIL sat_wide_sum: got %0d, want 262144 without ovf",
                           (q_imp.size() > 3) ? q_imp[3].v : -999);
      end
      tests++;
      if (yv_def !== 1'b0 || y_def !== 11'd1023 || ov_def !== 1'b1) begin
         fails++; $display("FAIL sat_hold: got v=%0b y=%0d ovf=%0b, want v=0 y=1023 ovf=1",
                           yv_def, y_def, ov_def);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) send(-256);
      tick();
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (y_def !== 11'd0 || y_imp !== 20'd0 || ov_def !== 1'b0) begin
         fails++; $display("FAIL async_reset: got y=%0d/%0d ovf=%0b, want 0/0 ovf=0",
                           y_def, y_imp, ov_def);
      end
      tick();
      reset_n = 1'b1;
      flush_q();
      for (int i = 0; i < 5; i++) send(i == 0 ? 1 : 0);
      idle(12);
      tests++;
      if (q_imp.size() !== 5) begin
         fails++; $display("FAIL post_reset_count: got %0d, want 5", q_imp.size());
      end
      for (int i = 0; i < 5; i++) begin
         tests++;
         if (i >= q_imp.size() || q_imp[i].v !== 0) begin
            fails++; $display("FAIL post_reset_y[%0d]: got %0d, want 0", i,
                              (i < q_imp.size()) ? q_imp[i].v : -999);
         end
      end
   endtask

   initial begin
      reset_n = 1'b0; clr = 1'b0; c_load = 1'b0; c_in = '0;
      x_valid = 1'b0; x_in = '0;
      test_reset();
      test_impulse();
      test_gapped();
      test_flush();
      test_concurrency();
      test_rounding();
      test_saturation();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
